// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with an 8-bit register file and a host port.
//
// Build option: define I2C_TGT_AUTOINC_EN to advance the register pointer
// after every data byte (NREG-1 wraps to 0, out-of-range pointer holds).
// Without it the pointer stays where the pointer phase left it.
//
// Ports:
//   clk, rstn              system clock, asynchronous active-low reset
//   scl_i, sda_i           raw bus pins
//   sda_oe                 1 = pull SDA low (open drain)
//   host_wr/addr/wdata     local register write port
//   host_rdata             combinational register read, 8'hFF out of range
//   i2c_wr_stb/i2c_wr_idx  one-cycle pulse and index for a bus write
//   busy                   addressed, from address match until STOP

module i2c_tgt_pin_filt #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Idle bus level is high, so everything resets to 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 != level) begin
        if (cnt == CW'(FILT_LEN - 1)) begin
          level <= s2;
          rise  <= s2;
          fall  <= ~s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module i2c_target_regs #(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter int unsigned NREG     = 16,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       host_wr,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       i2c_wr_stb,
  output logic [7:0] i2c_wr_idx,
  output logic       busy
);
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic       rw;
  logic [7:0] ptr;
  logic [7:0] ptr_next;
  logic       ptr_done;
  logic [7:0] regs [NREG];

  logic       scl_f, scl_rise, scl_fall;
  logic       sda_f, sda_rise, sda_fall;
  logic [7:0] byte_in;
  logic       ptr_ok;
  logic [7:0] rd_byte;

  i2c_tgt_pin_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rstn(rstn), .pin(scl_i),
    .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_tgt_pin_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rstn(rstn), .pin(sda_i),
    .level(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  always_comb begin
    byte_in = {shreg, sda_f};
    ptr_ok  = 32'(ptr) < NREG;
    rd_byte = ptr_ok ? regs[ptr[IW-1:0]] : 8'hFF;
  end

  always_comb begin
    host_rdata = (32'(host_addr) < NREG) ? regs[host_addr[IW-1:0]] : 8'hFF;
  end

`ifdef I2C_TGT_AUTOINC_EN
  always_comb begin
    ptr_next = ptr;
    if (ptr_ok) begin
      ptr_next = (32'(ptr) == NREG - 1) ? '0 : ptr + 8'd1;
    end
  end
`else
  always_comb begin
    ptr_next = ptr;
  end
`endif

  // ACK states enter with bit_cnt = 8 on the 8th rise; the following fall
  // drives ACK, the 9th rise bumps bit_cnt to 9, and the next fall leaves.
  // Read data: bit 7 is driven straight from rd_byte, shreg holds bits 6..0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rw         <= 1'b0;
      ptr        <= '0;
      ptr_done   <= 1'b0;
      sda_oe     <= 1'b0;
      i2c_wr_stb <= 1'b0;
      i2c_wr_idx <= '0;
      busy       <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[IW'(i)] <= '0;
      end
    end else begin
      i2c_wr_stb <= 1'b0;
      if (sda_fall && scl_f) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (sda_rise && scl_f) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        ptr_done <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd8;
                if (byte_in[7:1] == SLV_ADDR) begin
                  state <= ADDR_ACK;
                  rw    <= byte_in[0];
                  busy  <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd9;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (state == ADDR_ACK && rw) begin
                  state  <= RDATA;
                  shreg  <= rd_byte[6:0];
                  sda_oe <= ~rd_byte[7];
                end else begin
                  sda_oe <= 1'b0;
                  if (state == ADDR_ACK && !ptr_done) begin
                    state <= PTR;
                  end else begin
                    state <= WDATA;
                  end
                end
              end
            end
          end
          PTR: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                ptr      <= byte_in;
                ptr_done <= 1'b1;
                bit_cnt  <= 4'd8;
                state    <= PTR_ACK;
              end
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (ptr_ok) begin
                  regs[ptr[IW-1:0]] <= byte_in;
                  i2c_wr_stb        <= 1'b1;
                  i2c_wr_idx        <= ptr;
                end
                ptr     <= ptr_next;
                bit_cnt <= 4'd8;
                state   <= WDATA_ACK;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state  <= RACK;
                sda_oe <= 1'b0;
                ptr    <= ptr_next;
              end else begin
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[5:0], 1'b0};
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                state <= WAIT_STOP;
              end else begin
                bit_cnt <= 4'd9;
              end
            end else if (scl_fall) begin
              state   <= RDATA;
              bit_cnt <= '0;
              shreg   <= rd_byte[6:0];
              sda_oe  <= ~rd_byte[7];
            end
          end
          default: ;
        endcase
      end
      // Placed last so a same-cycle host write overrides the bus write.
      if (host_wr && (32'(host_addr) < NREG)) begin
        regs[host_addr[IW-1:0]] <= host_wdata;
      end
    end
  end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) responder with an 8-bit register file, the far end of the bus driven by the `i2c_core` master. It decodes START, STOP, address, register-pointer, write-data and read-data phases from the filtered SCL/SDA pins. SDA is driven open-drain for ACK and read data. Local logic reads and writes the same register file through a simple host port. Used for loopback verification of the I2C master and as a target inside system designs.

## Interface
- `SLV_ADDR`, 7'h50: 7-bit target address.
- `NREG`, 16: number of 8-bit registers (1..256).
- `FILT_LEN`, 4: glitch-filter length in clk cycles; a pin change is accepted only after it is stable this long.

- `clk`  in  1  system clock, at least 16× the SCL rate.
- `rstn`  in  1  asynchronous active-low reset.
- `scl_i`  in  1  SCL pin input.
- `sda_i`  in  1  SDA pin input.
- `sda_oe`  out  1  1 = pull SDA low; pad drives 0 when set, else high-Z.
- `host_wr`  in  1  host write strobe.
- `host_addr`  in  8  host register index.
- `host_wdata`  in  8  host write data.
- `host_rdata`  out  8  combinational read of `regs[host_addr]`; 8'hFF if `host_addr >= NREG`.
- `i2c_wr_stb`  out  1  one-cycle pulse when the bus writes a register.
- `i2c_wr_idx`  out  8  register index written, valid with `i2c_wr_stb`.
- `busy`  out  1  set while this target is addressed (ADDR match through STOP).

## Operation
- Input path: a 2-flop synchronizer per pin, then a FILT_LEN stable filter, giving `scl_f`/`sda_f` and their rise/fall pulses.
- START: `sda_f` falls while `scl_f` = 1. STOP: `sda_f` rises while `scl_f` = 1. START is accepted in every state, including repeated START. STOP returns the FSM to IDLE from every state.
- Bits are sampled on `scl_f` rise. `sda_oe` changes only on `scl_f` fall.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
  - ADDR: shift 8 bits. On match with `SLV_ADDR`, go to ADDR_ACK and latch the R/W bit. On mismatch, go to WAIT_STOP and do not drive SDA.
  - ADDR_ACK: drive ACK for the 9th clock. Then go to RDATA if R/W = 1. If R/W = 0, go to PTR on the first transfer after START, or to WDATA if the pointer was already written in this transaction.
  - PTR: shift 8 bits into `ptr`, then PTR_ACK (ACK always), then WDATA.
  - WDATA: shift 8 bits, then WDATA_ACK. At the 8th sampled bit: if `ptr < NREG`, write `regs[ptr]` and pulse `i2c_wr_stb` with `i2c_wr_idx` = `ptr`; otherwise discard the byte and still ACK.
  - RDATA: the shift register is loaded from `regs[ptr]` (8'hFF if `ptr >= NREG`) on the `scl_f` fall that ends the previous ACK. MSB first. `sda_oe` = ~bit.
  - RACK: release SDA and sample the master's ACK on the 9th rise. ACK (0) → RDATA with the next byte. NACK (1) → WAIT_STOP.
- Pointer update after each data byte (write or read) is set by the configuration macro.
- Host and bus writing the same register in the same cycle: the host write wins, and `i2c_wr_stb` still pulses.
- The register file resets to 8'h00.

## Timing
- Reset values: `sda_oe`=0, `i2c_wr_stb`=0, `i2c_wr_idx`=0, `busy`=0, FSM=IDLE, `ptr`=0, all regs=0.
- Pin-to-internal latency: 2 + FILT_LEN cycles.
- `sda_oe` asserts 1 cycle after the filtered `scl_f` fall ending bit 8. It releases 1 cycle after the `scl_f` fall ending bit 9.
- `i2c_wr_stb` is registered and occurs 1 cycle after the 8th-bit `scl_f` rise. The register file value is visible on `host_rdata` in the same cycle.
- If `rstn` is asserted mid-transfer, SDA is released immediately (asynchronous).

## Configuration
- `I2C_TGT_AUTOINC_EN` defined: `ptr` increments after every data byte. `ptr` = NREG-1 wraps to 0. `ptr` ≥ NREG stays unchanged.
- `I2C_TGT_AUTOINC_EN` not defined: `ptr` is fixed after the pointer phase. Repeated bytes access the same register.

## Test plan
- Write at 100 kHz: START, 0xA0, 0x03, 0x5A, STOP → three ACKs; `i2c_wr_stb` once with idx 3; `host_rdata`@3 = 0x5A; `busy` 0 after STOP.
- Combined read: host writes regs 4/5 = 0x11/0x22; bus sends START, 0xA0, 0x04, repeated START, 0xA1, reads 2 bytes (ACK then NACK), STOP → 0x11, 0x22 with AUTOINC_EN; 0x11, 0x11 without.
- Address mismatch: START, 0xB0, 0x00 → `sda_oe` never asserts, no write strobe, FSM stays in WAIT_STOP until STOP.
- Out-of-range: `ptr` = 0x20 with NREG=16: write 0x77 → ACKed, no strobe, regs unchanged; read → 0xFF.
- Wrap and collision: with AUTOINC_EN, write to 0x0F, 0xAA, 0xBB → regs 15 = 0xAA, reg 0 = 0xBB. A host write of 0x33 to reg 0 in the same cycle as the bus write leaves 0x33.
- Glitch/reset: a 2-cycle SCL pulse (< FILT_LEN) is ignored. `rstn` low during RDATA → `sda_oe`=0 at once, regs=0, and a later START is decoded normally.
